// File: rtl/rs_error_corrector.sv
// -----------------------------------------------------------------------------
// rs_error_corrector
//   Single-symbol error corrector for an RS(7,5) decoder over GF(8)
//   (primitive polynomial x^3+x+1, alpha = 3'b010). It accepts a received
//   word plus its syndromes s1/s2, then searches one symbol position per
//   cycle for the position k where s1*alpha^k == s2. The error magnitude is
//   carried along as q = s1*alpha^-k and is XORed into symbol k on a match.
//
//   Optional feature macro: RS_ERR_CNT_EN (saturating corrected/failed counters)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      codeword and syndromes present
//   in_ready      block can accept (IDLE only)
//   in_v          received codeword, symbol k at bits [3k+2:3k]
//   in_s1/in_s2   syndromes
//   out_valid     result present, held until out_ready
//   out_ready     downstream accepts the result
//   out_v         corrected codeword (raw word when uncorrectable)
//   out_corrected one symbol was modified
//   out_fail      syndrome pattern is uncorrectable
//   err_cnt_corr  saturating count of corrected words (RS_ERR_CNT_EN only)
//   err_cnt_fail  saturating count of failed words (RS_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
`ifndef N
`define N 7
`endif
`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 3
`endif

module rs_error_corrector (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [`N*`SYMBOL_WIDTH-1:0]       in_v,
    input  logic [`SYMBOL_WIDTH-1:0]          in_s1,
    input  logic [`SYMBOL_WIDTH-1:0]          in_s2,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [`N*`SYMBOL_WIDTH-1:0]       out_v,
    output logic                              out_corrected,
    output logic                              out_fail
`ifdef RS_ERR_CNT_EN
    ,
    output logic [7:0]                        err_cnt_corr,
    output logic [7:0]                        err_cnt_fail
`endif
);

    localparam int NS = `N;
    localparam int SW = `SYMBOL_WIDTH;
    localparam int W  = NS * SW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Multiply by alpha: shift left, fold x^3 back as x+1.
    function automatic logic [2:0] gf_mul_a(input logic [2:0] b);
        gf_mul_a = {b[1], b[0] ^ b[2], b[2]};
    endfunction

    // Multiply by alpha^6 (= alpha^-1 = x^2+1): shift right, fold x^-1 as x^2+1.
    function automatic logic [2:0] gf_mul_a6(input logic [2:0] b);
        gf_mul_a6 = {b[0], b[2], b[1] ^ b[0]};
    endfunction

    state_t          r_state;
    logic [W-1:0]    r_word;
    logic [SW-1:0]   r_s2;
    logic [2:0]      r_k;
    logic [SW-1:0]   r_p;
    logic [SW-1:0]   r_q;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_out_v;
    logic            r_out_corrected;
    logic            r_out_fail;

    state_t          w_state_nxt;
    logic [W-1:0]    w_word_nxt;
    logic [SW-1:0]   w_s2_nxt;
    logic [2:0]      w_k_nxt;
    logic [SW-1:0]   w_p_nxt;
    logic [SW-1:0]   w_q_nxt;
    logic            w_out_valid_nxt;
    logic [W-1:0]    w_out_v_nxt;
    logic            w_corr_nxt;
    logic            w_fail_nxt;
    logic [W-1:0]    w_fixed;
    logic            w_handshake;

    // Candidate repaired word: XOR current magnitude q into symbol k.
    always_comb begin
        w_fixed = r_word;
        for (int i = 0; i < NS; i++) begin
            if (r_k == 3'(i)) begin
                w_fixed[i*SW +: SW] = r_word[i*SW +: SW] ^ r_q;
            end else begin
                w_fixed[i*SW +: SW] = r_word[i*SW +: SW];
            end
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt     = r_state;
        w_word_nxt      = r_word;
        w_s2_nxt        = r_s2;
        w_k_nxt         = r_k;
        w_p_nxt         = r_p;
        w_q_nxt         = r_q;
        w_out_valid_nxt = r_out_valid;
        w_out_v_nxt     = r_out_v;
        w_corr_nxt      = r_out_corrected;
        w_fail_nxt      = r_out_fail;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_word_nxt = in_v;
                    w_s2_nxt   = in_s2;
                    if ((in_s1 == 3'd0) && (in_s2 == 3'd0)) begin
                        w_state_nxt     = ST_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_out_v_nxt     = in_v;
                        w_corr_nxt      = 1'b0;
                        w_fail_nxt      = 1'b0;
                    end else if ((in_s1 == 3'd0) || (in_s2 == 3'd0)) begin
                        w_state_nxt     = ST_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_out_v_nxt     = in_v;
                        w_corr_nxt      = 1'b0;
                        w_fail_nxt      = 1'b1;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                        w_k_nxt     = 3'd0;
                        w_p_nxt     = in_s1;
                        w_q_nxt     = in_s1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (r_p == r_s2) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_out_v_nxt     = w_fixed;
                    w_corr_nxt      = 1'b1;
                    w_fail_nxt      = 1'b0;
                end else if (r_k == 3'd6) begin
                    // Every nonzero s2/s1 is some alpha^k, so this is defensive only.
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_out_v_nxt     = r_word;
                    w_corr_nxt      = 1'b0;
                    w_fail_nxt      = 1'b1;
                end else begin
                    w_k_nxt = r_k + 3'd1;
                    w_p_nxt = gf_mul_a(r_p);
                    w_q_nxt = gf_mul_a6(r_q);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_word          <= '0;
            r_s2            <= 3'd0;
            r_k             <= 3'd0;
            r_p             <= 3'd0;
            r_q             <= 3'd0;
            r_in_ready      <= 1'b1;
            r_out_valid     <= 1'b0;
            r_out_v         <= '0;
            r_out_corrected <= 1'b0;
            r_out_fail      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_word          <= w_word_nxt;
            r_s2            <= w_s2_nxt;
            r_k             <= w_k_nxt;
            r_p             <= w_p_nxt;
            r_q             <= w_q_nxt;
            r_in_ready      <= (w_state_nxt == ST_IDLE);
            r_out_valid     <= w_out_valid_nxt;
            r_out_v         <= w_out_v_nxt;
            r_out_corrected <= w_corr_nxt;
            r_out_fail      <= w_fail_nxt;
        end
    end

    assign w_handshake   = r_out_valid && out_ready;
    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_v         = r_out_v;
    assign out_corrected = r_out_corrected;
    assign out_fail      = r_out_fail;

`ifdef RS_ERR_CNT_EN
    logic [7:0] r_cnt_corr;
    logic [7:0] r_cnt_fail;

    // Saturating result counters, advanced on each output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_corr <= 8'd0;
            r_cnt_fail <= 8'd0;
        end else begin
            if (w_handshake && r_out_corrected && (r_cnt_corr != 8'd255)) begin
                r_cnt_corr <= r_cnt_corr + 8'd1;
            end else begin
                r_cnt_corr <= r_cnt_corr;
            end
            if (w_handshake && r_out_fail && (r_cnt_fail != 8'd255)) begin
                r_cnt_fail <= r_cnt_fail + 8'd1;
            end else begin
                r_cnt_fail <= r_cnt_fail;
            end
        end
    end

    assign err_cnt_corr = r_cnt_corr;
    assign err_cnt_fail = r_cnt_fail;
`else
    logic w_unused;
    assign w_unused = w_handshake;
`endif

endmodule

// File: tb/tb_rs_error_corrector.sv
// -----------------------------------------------------------------------------
// tb_rs_error_corrector
//   Directed self-checking bench for rs_error_corrector. Expected words,
//   flags and latencies are hand-computed in GF(8) with x^3+x+1
//   (alpha^1..6 = 010,100,011,110,111,101).
// -----------------------------------------------------------------------------
module tb_rs_error_corrector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_v;
    logic [2:0]  in_s1;
    logic [2:0]  in_s2;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_v;
    logic        out_corrected;
    logic        out_fail;
`ifdef RS_ERR_CNT_EN
    logic [7:0]  err_cnt_corr;
    logic [7:0]  err_cnt_fail;
`endif

    int n_tests;
    int n_fail;

    rs_error_corrector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_v          (in_v),
        .in_s1         (in_s1),
        .in_s2         (in_s2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_v         (out_v),
        .out_corrected (out_corrected),
        .out_fail      (out_fail)
`ifdef RS_ERR_CNT_EN
        ,
        .err_cnt_corr  (err_cnt_corr),
        .err_cnt_fail  (err_cnt_fail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word; returns in the cycle after the accept edge (cycle 1).
    task automatic send(input logic [20:0] v, input logic [2:0] s1, input logic [2:0] s2);
        in_v     = v;
        in_s1    = s1;
        in_s2    = s2;
        in_valid = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid; bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_v !== 21'h0 || out_corrected !== 1'b0 || out_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b v=%h corr=%b fail=%b required 0/0/0/0",
                     out_valid, out_v, out_corrected, out_fail);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
`ifdef RS_ERR_CNT_EN
        n_tests++;
        if (err_cnt_corr !== 8'd0 || err_cnt_fail !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counters: corr=%0d fail=%0d required 0/0", err_cnt_corr, err_cnt_fail);
        end
`endif
    endtask

    task automatic test_no_error();
        int lat;
        send(21'h0AB3F9, 3'd0, 3'd0);
        wait_valid(lat);
        n_tests++;
        if (lat !== 1 || out_v !== 21'h0AB3F9 || out_corrected !== 1'b0 || out_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL no_error: lat=%0d v=%h corr=%b fail=%b required 1/0ab3f9/0/0",
                     lat, out_v, out_corrected, out_fail);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL no_error_busy: in_ready=%b required 0", in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_error_release: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_correct();
        // {raw word, s1, s2, expected word, expected latency}
        logic [20:0] vin  [4] = '{21'h000001, 21'h000200, 21'h092345, 21'h1000C0};
        logic [2:0]  s1   [4] = '{3'b001, 3'b011, 3'b001, 3'b111};
        logic [2:0]  s2   [4] = '{3'b001, 3'b101, 3'b101, 3'b001};
        logic [20:0] vexp [4] = '{21'h000000, 21'h000000, 21'h012345, 21'h100000};
        int          lexp [4] = '{2, 5, 8, 4};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(vin[i], s1[i], s2[i]);
            wait_valid(lat);
            n_tests++;
            if (lat !== lexp[i] || out_v !== vexp[i] || out_corrected !== 1'b1 || out_fail !== 1'b0) begin
                n_fail++;
                $display("FAIL correct_%0d: lat=%0d v=%h corr=%b fail=%b required %0d/%h/1/0",
                         i, lat, out_v, out_corrected, out_fail, lexp[i], vexp[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_fail();
        logic [20:0] vin [2] = '{21'h1FFFFF, 21'h012345};
        logic [2:0]  s1  [2] = '{3'b001, 3'b000};
        logic [2:0]  s2  [2] = '{3'b000, 3'b100};
        int lat;
        for (int i = 0; i < 2; i++) begin
            send(vin[i], s1[i], s2[i]);
            wait_valid(lat);
            n_tests++;
            if (lat !== 1 || out_v !== vin[i] || out_corrected !== 1'b0 || out_fail !== 1'b1) begin
                n_fail++;
                $display("FAIL uncorrectable_%0d: lat=%0d v=%h corr=%b fail=%b required 1/%h/0/1",
                         i, lat, out_v, out_corrected, out_fail, vin[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
`ifdef RS_ERR_CNT_EN
        n_tests++;
        if (err_cnt_corr !== 8'd4 || err_cnt_fail !== 8'd2) begin
            n_fail++;
            $display("FAIL counters: corr=%0d fail=%0d required 4/2", err_cnt_corr, err_cnt_fail);
        end
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        send(21'h000001, 3'b001, 3'b001);
        wait_valid(lat);
        for (int c = 0; c < 3; c++) begin
            // A competing word is offered while busy; it must be ignored.
            in_v     = 21'h0AB3F9;
            in_s1    = 3'd0;
            in_s2    = 3'd0;
            in_valid = 1'b1;
            n_tests++;
            if (out_valid !== 1'b1 || out_v !== 21'h0 || out_corrected !== 1'b1 ||
                out_fail !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d: valid=%b v=%h corr=%b fail=%b rdy=%b required 1/000000/1/0/0",
                         c, out_valid, out_v, out_corrected, out_fail, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_v !== 21'h0AB3F9 || out_corrected !== 1'b0 || out_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_next: valid=%b v=%h corr=%b fail=%b required 1/0ab3f9/0/0",
                     out_valid, out_v, out_corrected, out_fail);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_search();
        logic seen;
        send(21'h092345, 3'b001, 3'b101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midsearch_reset: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midsearch_stale: stale_valid=%b in_ready=%b required 0/1", seen, in_ready);
        end
`ifdef RS_ERR_CNT_EN
        n_tests++;
        if (err_cnt_corr !== 8'd0 || err_cnt_fail !== 8'd0) begin
            n_fail++;
            $display("FAIL midsearch_counters: corr=%0d fail=%0d required 0/0", err_cnt_corr, err_cnt_fail);
        end
`endif
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_v      = 21'h0;
        in_s1     = 3'd0;
        in_s2     = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_no_error();
        test_correct();
        test_fail();
        test_backpressure();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
